// File: rtl/vball_pkg.sv
// Shared definitions for the vball graphics ROM arbiter.
// Holds the sequencer state encoding, the channel identifiers used by the
// grant logic, the default gfx bus widths and a small saturating-counter
// helper shared by the run-length tracking.
package vball_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CH_BG  = 1'b0;
    localparam logic CH_SPR = 1'b1;

    localparam int GFX_ADDR_W = 19;
    localparam int GFX_DATA_W = 8;

    // 4-bit increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vball_arb_pick.sv
// Grant selection for the gfx ROM arbiter.
// Combinationally chooses which channel wins the next read and keeps the
// fairness history (last granted channel, consecutive background grants
// while the sprite fetcher waits). History only moves when grant_en says
// the top is actually issuing a read this cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   bg_req     : background fetcher request
//   spr_req    : sprite fetcher request
//   grant_en   : a read is being granted this cycle
//   pick       : winning channel (CH_BG / CH_SPR), valid while any req high
module vball_arb_pick
    import vball_pkg::*;
#(
    parameter int BG_PRIO    = 1,
    parameter int MAX_BG_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bg_req,
    input  logic spr_req,
    input  logic grant_en,
    output logic pick
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_BG_RUN);

    logic       rr_last;
    logic [3:0] bg_run;

    // Winner selection: priority-with-cap or round-robin.
    always_comb begin
        pick = CH_BG;
        if (BG_PRIO != 0) begin
            // Background keeps winning until the sprite has watched it win
            // MAX_BG_RUN times in a row.
            if (bg_req && !(spr_req && (bg_run == MAX_RUN))) begin
                pick = CH_BG;
            end else if (spr_req) begin
                pick = CH_SPR;
            end else begin
                pick = CH_BG;
            end
        end else begin
            if (bg_req && spr_req) begin
                pick = ~rr_last;
            end else if (spr_req) begin
                pick = CH_SPR;
            end else begin
                pick = CH_BG;
            end
        end
    end

    // Fairness history, updated only on an actual grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= CH_SPR;
            bg_run  <= 4'd0;
        end else if (grant_en) begin
            rr_last <= pick;
            // Only a background win that made the sprite wait extends the run.
            if ((pick == CH_BG) && spr_req) begin
                bg_run <= sat_inc4(bg_run);
            end else begin
                bg_run <= 4'd0;
            end
        end else begin
            rr_last <= rr_last;
            bg_run  <= bg_run;
        end
    end

endmodule

// File: rtl/vball_gfx_arb.sv
// Shares the single external graphics ROM read port between the background
// tile fetcher (channel 0) and the sprite fetcher (channel 1).
// One fixed-latency read is in flight at a time: IDLE grants and latches the
// address, READ holds gfx_read for RD_LAT cycles, DONE pulses the ack of the
// granted channel with its data register freshly loaded.
//   clk_sys, reset      : clock, asynchronous active-high reset
//   bg_req/bg_addr      : background request + address (held until bg_ack)
//   bg_ack/bg_data      : one-cycle ack, data held until the next bg_ack
//   spr_req/spr_addr    : sprite request + address (held until spr_ack)
//   spr_ack/spr_data    : one-cycle ack, data held until the next spr_ack
//   gfx_read/gfx_addr   : external read strobe and address
//   gfx_data            : external read data
//   busy                : high whenever the sequencer is not idle
module vball_gfx_arb
    import vball_pkg::*;
#(
    parameter int ADDR_W     = GFX_ADDR_W,
    parameter int DATA_W     = GFX_DATA_W,
    parameter int RD_LAT     = 4,
    parameter int BG_PRIO    = 1,
    parameter int MAX_BG_RUN = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_ack,
    output logic [DATA_W-1:0] bg_data,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic [DATA_W-1:0] spr_data,
    output logic              gfx_read,
    output logic [ADDR_W-1:0] gfx_addr,
    input  logic [DATA_W-1:0] gfx_data,
    output logic              busy
);

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       grant_ch;
    logic       pick_ch;
    logic       any_req;
    logic       grant_en;

    assign any_req  = bg_req | spr_req;
    assign grant_en = (state == IDLE) && any_req;

    vball_arb_pick #(
        .BG_PRIO    (BG_PRIO),
        .MAX_BG_RUN (MAX_BG_RUN)
    ) u_pick (
        .clk      (clk_sys),
        .rst      (reset),
        .bg_req   (bg_req),
        .spr_req  (spr_req),
        .grant_en (grant_en),
        .pick     (pick_ch)
    );

    // Read sequencer and datapath; every output is a register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            grant_ch <= CH_BG;
            gfx_read <= 1'b0;
            gfx_addr <= '0;
            bg_ack   <= 1'b0;
            spr_ack  <= 1'b0;
            bg_data  <= '0;
            spr_data <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bg_ack  <= 1'b0;
                    spr_ack <= 1'b0;
                    if (any_req) begin
                        grant_ch <= pick_ch;
                        // The address is latched here; later changes on the
                        // request side do not disturb the read in flight.
                        if (pick_ch == CH_SPR) begin
                            gfx_addr <= spr_addr;
                        end else begin
                            gfx_addr <= bg_addr;
                        end
                        cnt      <= LAT_M1;
                        gfx_read <= 1'b1;
                        busy     <= 1'b1;
                        state    <= READ;
                    end else begin
                        gfx_read <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                READ: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Last strobe cycle: ROM data is valid now.
                        if (grant_ch == CH_SPR) begin
                            spr_data <= gfx_data;
                            spr_ack  <= 1'b1;
                        end else begin
                            bg_data <= gfx_data;
                            bg_ack  <= 1'b1;
                        end
                        gfx_read <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bg_ack  <= 1'b0;
                    spr_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    gfx_read <= 1'b0;
                    bg_ack   <= 1'b0;
                    spr_ack  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vball_gfx_arb.sv
// Bench for vball_gfx_arb. Two instances: u_dut0 (RD_LAT=4, background
// priority, run cap 4) and u_dut1 (RD_LAT=1, round-robin). A transaction
// level reference model predicts, cycle by cycle, strobe/busy/ack/data for
// each instance from the arbitration rules; directed steps are followed by
// a randomized request phase.
module tb_vball_gfx_arb;

    localparam int AW   = 19;
    localparam int DW   = 8;
    localparam int MAXR = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic          rst      [2];
    logic          bg_req   [2];
    logic [AW-1:0] bg_addr  [2];
    logic          bg_ack   [2];
    logic [DW-1:0] bg_data  [2];
    logic          spr_req  [2];
    logic [AW-1:0] spr_addr [2];
    logic          spr_ack  [2];
    logic [DW-1:0] spr_data [2];
    logic          gfx_read [2];
    logic [AW-1:0] gfx_addr [2];
    logic [DW-1:0] gfx_data [2];
    logic          busy     [2];

    vball_gfx_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4), .BG_PRIO(1), .MAX_BG_RUN(MAXR)) u_dut0 (
        .clk_sys(clk_sys), .reset(rst[0]),
        .bg_req(bg_req[0]), .bg_addr(bg_addr[0]), .bg_ack(bg_ack[0]), .bg_data(bg_data[0]),
        .spr_req(spr_req[0]), .spr_addr(spr_addr[0]), .spr_ack(spr_ack[0]), .spr_data(spr_data[0]),
        .gfx_read(gfx_read[0]), .gfx_addr(gfx_addr[0]), .gfx_data(gfx_data[0]), .busy(busy[0]));

    vball_gfx_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .BG_PRIO(0), .MAX_BG_RUN(MAXR)) u_dut1 (
        .clk_sys(clk_sys), .reset(rst[1]),
        .bg_req(bg_req[1]), .bg_addr(bg_addr[1]), .bg_ack(bg_ack[1]), .bg_data(bg_data[1]),
        .spr_req(spr_req[1]), .spr_addr(spr_addr[1]), .spr_ack(spr_ack[1]), .spr_data(spr_data[1]),
        .gfx_read(gfx_read[1]), .gfx_addr(gfx_addr[1]), .gfx_data(gfx_data[1]), .busy(busy[1]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit prio_of(input int i);
        return (i == 0);
    endfunction

    // ROM contents: 8'hA5 at 19'h12345.
    function automatic logic [7:0] mem(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'hC2;
    endfunction

    // ROM model: data is only correct once the strobe has been high for
    // RD_LAT cycles; before that it returns the complement.
    int hi_cnt [2];
    always @(posedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            hi_cnt[i] <= gfx_read[i] ? hi_cnt[i] + 1 : 0;
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gfx_data[i] = (gfx_read[i] && (hi_cnt[i] >= lat_of(i) - 1)) ? mem(gfx_addr[i]) : ~mem(gfx_addr[i]);
        end
    end

    // Reference model state
    int          cyc;
    bit          act       [2];
    int          t0        [2];
    int          idle_from [2];
    bit          win       [2];
    logic [18:0] taddr     [2];
    int          run_m     [2];
    bit          last_m    [2];
    logic [7:0]  ed        [2][2];
    bit          rep       [2][2];
    bit          rnd       [2];

    // Observation logs
    int gq0 [$];
    int gq1 [$];
    int bgc1 [$];
    int bg_ack_cyc0;
    int spr_acks0;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic req_of(input int i, input int c);
        return (c == 0) ? bg_req[i] : spr_req[i];
    endfunction

    function automatic logic [18:0] addr_of(input int i, input int c);
        return (c == 0) ? bg_addr[i] : spr_addr[i];
    endfunction

    task automatic set_ch(input int i, input int c, input logic v, input logic [18:0] a);
        if (c == 0) begin
            bg_req[i]  = v;
            bg_addr[i] = a;
        end else begin
            spr_req[i]  = v;
            spr_addr[i] = a;
        end
    endtask

    // Model arbitration for the current (idle) cycle using the driven requests.
    task automatic arbitrate(input int i);
        bit b, s, w;
        if (!rst[i] && !act[i] && (cyc >= idle_from[i]) && (bg_req[i] || spr_req[i])) begin
            b = bg_req[i];
            s = spr_req[i];
            if (prio_of(i)) begin
                w = (b && !(s && run_m[i] == MAXR)) ? 1'b0 : 1'b1;
                run_m[i] = (!w && s) ? ((run_m[i] < 15) ? run_m[i] + 1 : 15) : 0;
            end else begin
                w = (b && s) ? !last_m[i] : s;
            end
            last_m[i] = w;
            act[i]    = 1'b1;
            t0[i]     = cyc;
            win[i]    = w;
            taddr[i]  = w ? spr_addr[i] : bg_addr[i];
        end
    endtask

    // Compare one instance against the model for this cycle, then let the
    // requesters react to the acks.
    task automatic check_inst(input int i);
        bit e_rd, e_busy;
        bit [1:0] ea;
        logic [18:0] ra;
        e_rd = 1'b0; e_busy = 1'b0; ea = 2'b00;
        if (act[i]) begin
            if (cyc <= t0[i] + lat_of(i)) begin
                e_rd = 1'b1; e_busy = 1'b1;
            end else begin
                e_busy = 1'b1;
                ea[win[i]] = 1'b1;
                ed[i][win[i]] = mem(taddr[i]);
                act[i] = 1'b0;
                idle_from[i] = cyc + 1;
            end
        end
        chk($sformatf("i%0d gfx_read c%0d", i, cyc), 32'(gfx_read[i]), 32'(e_rd));
        chk($sformatf("i%0d busy c%0d", i, cyc), 32'(busy[i]), 32'(e_busy));
        chk($sformatf("i%0d bg_ack c%0d", i, cyc), 32'(bg_ack[i]), 32'(ea[0]));
        chk($sformatf("i%0d spr_ack c%0d", i, cyc), 32'(spr_ack[i]), 32'(ea[1]));
        chk($sformatf("i%0d bg_data c%0d", i, cyc), 32'(bg_data[i]), 32'(ed[i][0]));
        chk($sformatf("i%0d spr_data c%0d", i, cyc), 32'(spr_data[i]), 32'(ed[i][1]));
        if (e_rd) chk($sformatf("i%0d gfx_addr c%0d", i, cyc), 32'(gfx_addr[i]), 32'(taddr[i]));
        if (i == 0) begin
            if (bg_ack[0]) begin gq0.push_back(0); bg_ack_cyc0 = cyc; end
            if (spr_ack[0]) begin gq0.push_back(1); spr_acks0++; end
        end else begin
            if (bg_ack[1]) begin gq1.push_back(0); bgc1.push_back(cyc); end
            if (spr_ack[1]) gq1.push_back(1);
        end
        for (int c = 0; c < 2; c++) begin
            ra = 19'($urandom);
            if (ea[c]) begin
                if (rnd[i]) begin
                    if ($urandom_range(0, 1) == 1) set_ch(i, c, 1'b1, ra);
                    else set_ch(i, c, 1'b0, addr_of(i, c));
                end else if (rep[i][c]) begin
                    set_ch(i, c, 1'b1, addr_of(i, c) + 19'd1);
                end else begin
                    set_ch(i, c, 1'b0, addr_of(i, c));
                end
            end else if (rnd[i]) begin
                if (!req_of(i, c)) begin
                    if ($urandom_range(0, 2) == 0) set_ch(i, c, 1'b1, ra);
                end else if (act[i] && (win[i] == 1'(c)) && ($urandom_range(0, 3) == 0)) begin
                    // address wiggle during the granted read must be ignored
                    set_ch(i, c, 1'b1, ra);
                end
            end
        end
    endtask

    task automatic step();
        arbitrate(0);
        arbitrate(1);
        @(posedge clk_sys);
        #1;
        cyc++;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic hit_reset(input int i);
        rst[i] = 1'b1;
        #1;
        chk($sformatf("i%0d rst gfx_read", i), 32'(gfx_read[i]), 32'd0);
        chk($sformatf("i%0d rst busy", i), 32'(busy[i]), 32'd0);
        chk($sformatf("i%0d rst bg_ack", i), 32'(bg_ack[i]), 32'd0);
        chk($sformatf("i%0d rst spr_ack", i), 32'(spr_ack[i]), 32'd0);
        chk($sformatf("i%0d rst bg_data", i), 32'(bg_data[i]), 32'd0);
        chk($sformatf("i%0d rst spr_data", i), 32'(spr_data[i]), 32'd0);
        act[i] = 1'b0; ed[i][0] = 8'd0; ed[i][1] = 8'd0; run_m[i] = 0; last_m[i] = 1'b1;
    endtask

    int t_req;
    int n0;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; bg_ack_cyc0 = 0; spr_acks0 = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; bg_req[i] = 1'b0; spr_req[i] = 1'b0;
            bg_addr[i] = 19'd0; spr_addr[i] = 19'd0;
            act[i] = 1'b0; t0[i] = 0; idle_from[i] = 0; win[i] = 1'b0; taddr[i] = 19'd0;
            run_m[i] = 0; last_m[i] = 1'b1; rnd[i] = 1'b0;
            for (int c = 0; c < 2; c++) begin ed[i][c] = 8'd0; rep[i][c] = 1'b0; end
        end

        // Reset state
        repeat (2) step();
        rst[0] = 1'b0; rst[1] = 1'b0; idle_from[0] = cyc; idle_from[1] = cyc;
        step();

        // Round-robin contention on u_dut1: bg,spr,bg,spr
        gq1.delete();
        bg_addr[1] = 19'h00100; spr_addr[1] = 19'h40000;
        rep[1][0] = 1'b1; rep[1][1] = 1'b1; bg_req[1] = 1'b1; spr_req[1] = 1'b1;
        repeat (6) step();
        chk("rr spr_data@40000", 32'(spr_data[1]), 32'(mem(19'h40000)));
        repeat (5) step();
        rep[1][0] = 1'b0; rep[1][1] = 1'b0; bg_req[1] = 1'b0; spr_req[1] = 1'b0;
        step();
        chk("rr grant count", 32'(gq1.size()), 32'd4);
        foreach (gq1[k]) chk($sformatf("rr grant %0d", k), 32'(gq1[k]), 32'(k % 2));

        // RD_LAT=1 back-to-back bg reads at 0,1,2
        bgc1.delete();
        bg_addr[1] = 19'd0; rep[1][0] = 1'b1; bg_req[1] = 1'b1;
        repeat (8) step();
        bg_req[1] = 1'b0; rep[1][0] = 1'b0;
        step();
        chk("lat1 ack count", 32'(bgc1.size()), 32'd3);
        for (int k = 1; k < bgc1.size(); k++) chk($sformatf("lat1 ack gap %0d", k), 32'(bgc1[k] - bgc1[k-1]), 32'd3);
        chk("lat1 bg_data@2", 32'(bg_data[1]), 32'(mem(19'd2)));

        // Single bg read on u_dut0
        n0 = spr_acks0;
        bg_addr[0] = 19'h12345; bg_req[0] = 1'b1; t_req = cyc;
        repeat (7) step();
        chk("single latency", 32'(bg_ack_cyc0 - t_req + 1), 32'd6);
        chk("single bg_data", 32'(bg_data[0]), 32'h0000_00A5);
        chk("single no spr_ack", 32'(spr_acks0 - n0), 32'd0);

        // Priority contention with run cap 4
        gq0.delete();
        bg_addr[0] = 19'h01000; spr_addr[0] = 19'h22000;
        rep[0][0] = 1'b1; rep[0][1] = 1'b1; bg_req[0] = 1'b1; spr_req[0] = 1'b1;
        repeat (59) step();
        rep[0][0] = 1'b0; rep[0][1] = 1'b0; bg_req[0] = 1'b0; spr_req[0] = 1'b0;
        step();
        chk("prio grant count", 32'(gq0.size()), 32'd10);
        foreach (gq0[k]) chk($sformatf("prio grant %0d", k), 32'(gq0[k]), (k % 5 == 4) ? 32'd1 : 32'd0);

        // Sprite request dropped one cycle after grant
        n0 = spr_acks0;
        spr_addr[0] = 19'h3ABCD; spr_req[0] = 1'b1;
        step();
        spr_req[0] = 1'b0;
        repeat (7) step();
        chk("drop spr_ack once", 32'(spr_acks0 - n0), 32'd1);
        chk("drop busy idle", 32'(busy[0]), 32'd0);
        chk("drop spr_data", 32'(spr_data[0]), 32'(mem(19'h3ABCD)));

        // Reset during the second READ cycle, then a fresh read
        bg_addr[0] = 19'h12345; bg_req[0] = 1'b1;
        repeat (2) step();
        hit_reset(0);
        step();
        rst[0] = 1'b0; idle_from[0] = cyc;
        step();
        chk("fresh read after reset", 32'(gfx_read[0]), 32'd1);
        repeat (6) step();

        // Randomized traffic on both instances, then drain
        rnd[0] = 1'b1; rnd[1] = 1'b1;
        repeat (800) step();
        rnd[0] = 1'b0; rnd[1] = 1'b0;
        repeat (40) step();
        chk("drain busy0", 32'(busy[0]), 32'd0);
        chk("drain busy1", 32'(busy[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vball_gfx_arb.md
Name: vball_gfx_arb

Overview:
- Arbiter/sequencer sharing the single external graphics ROM read port (gfx_read/gfx_addr/gfx_data) between two requesters: the background tile fetcher (channel 0) and the sprite fetcher (channel 1).
- Sits in vball between the video fetch engines and the top-level gfx port.
- Issues one fixed-latency read at a time, returns data with a one-cycle ack pulse, and bounds starvation of the sprite channel.

Parameters:
ADDR_W, 19, gfx address width
DATA_W, 8, gfx data width
RD_LAT, 4, cycles from first gfx_read-high cycle to valid gfx_data (legal 1..15)
BG_PRIO, 1, 1 = background priority with run cap; 0 = strict round-robin
MAX_BG_RUN, 4, consecutive bg grants allowed while spr waits (BG_PRIO=1 only; legal 1..15)

Ports:
clk_sys  in  1  system clock (48 MHz)
reset  in  1  asynchronous, active-high reset
bg_req  in  1  bg read request; held with bg_addr stable until bg_ack
bg_addr  in  ADDR_W  bg read address
bg_ack  out  1  one-cycle pulse; bg_data valid this cycle
bg_data  out  DATA_W  bg read data, held until next bg_ack
spr_req  in  1  sprite read request, same rules as bg_req
spr_addr  in  ADDR_W  sprite read address
spr_ack  out  1  one-cycle pulse; spr_data valid this cycle
spr_data  out  DATA_W  sprite read data, held until next spr_ack
gfx_read  out  1  external read strobe (level)
gfx_addr  out  ADDR_W  external address
gfx_data  in  DATA_W  external read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, bg_run=0, rr_last=1 (next round-robin winner is bg).
- FSM states: IDLE, READ, DONE.
- IDLE: sample requests, decide grant (registered), latch the granted address into gfx_addr.
  - Any req -> READ. gfx_read=1 from the next cycle. Load cnt=RD_LAT-1.
  - No req -> stay in IDLE.
- READ: gfx_read=1; gfx_addr stable.
  - cnt>0: decrement.
  - cnt==0: capture gfx_data into the granted channel's data register; -> DONE.
- DONE: gfx_read=0; pulse the granted ack for exactly one cycle; -> IDLE.
- Timing:
  - Latency from req high in IDLE to ack = RD_LAT+2 cycles.
  - Back-to-back throughput: one read per RD_LAT+2 cycles.
  - A req held through DONE is re-arbitrated in the following IDLE.
- Grant, BG_PRIO=1:
  - bg wins unless spr_req && bg_run==MAX_BG_RUN.
  - A bg grant while spr_req is high increments bg_run (saturating).
  - A spr grant, or a bg grant with spr_req low, clears bg_run.
- Grant, BG_PRIO=0:
  - With both requesting, grant the channel not equal to rr_last.
  - A single requester always wins.
  - rr_last is updated on every grant.
- Req deasserted mid-transaction: the transaction completes and the ack still pulses; the requester ignores it.
- Address change mid-transaction: ignored; the latched address is used.
- Simultaneous events: a req rising in the same cycle as DONE is not seen until IDLE. No ack pulses for both channels in the same cycle.
- Reset mid-transaction: immediate return to IDLE; gfx_read and acks drop to 0; data registers cleared; no ack is issued for the aborted read.
- Widths: cnt is 4 bits; bg_run is 4 bits, saturating at 15.

Decomposition:
- Shared package vball_pkg holds:
  - FSM state encoding (IDLE=2'd0, READ=2'd1, DONE=2'd2);
  - channel ids CH_BG=1'b0, CH_SPR=1'b1;
  - default GFX_ADDR_W=19.
- One natural sub-module: vball_arb_pick, a combinational plus rr_last/bg_run register block that selects the grant. The FSM and datapath stay in the top.

Test Plan:
- Single bg read: bg_req=1, bg_addr=19'h12345, model returns 8'hA5 RD_LAT=4 cycles after gfx_read rises -> gfx_addr=12345 with gfx_read high for 4 cycles; bg_ack pulses at cycle 6 with bg_data=A5; spr_ack stays 0.
- Contention, BG_PRIO=1, MAX_BG_RUN=4, both reqs held continuously -> grant sequence bg,bg,bg,bg,spr,bg,bg,bg,bg,spr.
- Contention, BG_PRIO=0, both held -> strict alternation bg,spr,bg,spr; spr_data equals the model value for spr_addr=19'h40000.
- Req dropped in READ: spr_req falls one cycle after grant -> read completes, spr_ack pulses once, busy returns to 0; no second read is issued.
- Reset asserted on the 2nd cycle of READ -> gfx_read, busy, bg_ack and bg_data go to 0 asynchronously. After release with bg_req=1, a fresh read starts one cycle later.
- RD_LAT=1 corner: back-to-back bg reads at addresses 0, 1, 2 -> acks exactly 3 cycles apart; data matches the model; gfx_read never high in DONE.
